// File: rtl/board_scanner.sv
// Streams a snapshot of the 81-cell board one cell per handshake,
// then reports hidden-cell count, win and loss for that frame.
module board_scanner #(
  parameter logic [2:0] PERCORRER_NUMEROS = 3'b100,
  parameter logic [3:0] HIDDEN_CODE       = 4'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   current_state,
  input  logic         start,
  input  logic [323:0] board,
  input  logic [80:0]  visibilities,
  input  logic [3:0]   selected_number,
  input  logic [1:0]   strikes,
  output logic         cell_valid,
  input  logic         cell_ready,
  output logic [6:0]   cell_index,
  output logic [3:0]   cell_digit,
  output logic         cell_highlight,
  output logic         busy,
  output logic         frame_done,
  output logic [6:0]   hidden_count,
  output logic         won,
  output logic         lost
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_e;

  state_e         state_q;
  logic [323:0]   board_q;
  logic [80:0]    vis_q;
  logic [3:0]     sel_q;
  logic [1:0]     strikes_q;
  logic [6:0]     idx_q;
  logic [6:0]     hcnt_q;
  logic [6:0]     hidden_q;
  logic           won_q;
  logic           lost_q;
  logic           valid_q;
  logic           busy_q;
  logic           done_q;

  logic [3:0]     raw_dig;
  logic           cell_vis;
  logic           xfer;
  logic           last;
  logic           run_ok;
  logic [6:0]     hcnt_d;

  // Everything shown on the cell port comes from the shadow copy.
  assign raw_dig  = board_q[{idx_q, 2'b00} +: 4];
  assign cell_vis = vis_q[idx_q];
  assign xfer     = valid_q & cell_ready;
  assign last     = (idx_q == 7'd80);
  assign run_ok   = (current_state == PERCORRER_NUMEROS);
  assign hcnt_d   = hcnt_q + {6'd0, ~cell_vis};

  assign cell_valid     = valid_q;
  assign cell_index     = idx_q;
  assign cell_digit     = !valid_q ? 4'd0 :
                          (cell_vis ? raw_dig : HIDDEN_CODE);
  assign cell_highlight = valid_q & cell_vis
                        & (raw_dig == sel_q);
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign hidden_count   = hidden_q;
  assign won            = won_q;
  assign lost           = lost_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      board_q   <= '0;
      vis_q     <= '0;
      sel_q     <= '0;
      strikes_q <= '0;
      idx_q     <= '0;
      hcnt_q    <= '0;
      hidden_q  <= '0;
      won_q     <= 1'b0;
      lost_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && run_ok) begin
            board_q   <= board;
            vis_q     <= visibilities;
            sel_q     <= selected_number;
            strikes_q <= strikes;
            hcnt_q    <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_STREAM;
          end
        end
        S_STREAM: begin
          // The final transfer wins over an abort in the same cycle.
          if (xfer && last) begin
            hcnt_q   <= hcnt_d;
            hidden_q <= hcnt_d;
            won_q    <= (hcnt_d == 7'd0);
            lost_q   <= (strikes_q == 2'b11);
            valid_q  <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (!run_ok) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (xfer) begin
            hcnt_q <= hcnt_d;
            idx_q  <= idx_q + 7'd1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_scanner.sv
// Scoreboard bench for board_scanner: expected cells and frame
// results are queued at start and popped as the DUT delivers them.
module tb_board_scanner;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   current_state;
  logic         start;
  logic [323:0] board;
  logic [80:0]  visibilities;
  logic [3:0]   selected_number;
  logic [1:0]   strikes;
  logic         cell_valid;
  logic         cell_ready;
  logic [6:0]   cell_index;
  logic [3:0]   cell_digit;
  logic         cell_highlight;
  logic         busy;
  logic         frame_done;
  logic [6:0]   hidden_count;
  logic         won;
  logic         lost;

  typedef struct packed {
    logic [6:0] idx;
    logic [3:0] dig;
    logic       hl;
  } cell_t;

  typedef struct packed {
    logic [6:0] h;
    logic       w;
    logic       l;
  } res_t;

  cell_t exp_q[$];
  res_t  res_q[$];
  res_t  last_res;

  int n_chk    = 0;
  int n_err    = 0;
  int cyc_n    = 0;
  int t0       = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;

  board_scanner dut (
    .clk            (clk),
    .reset          (reset),
    .current_state  (current_state),
    .start          (start),
    .board          (board),
    .visibilities   (visibilities),
    .selected_number(selected_number),
    .strikes        (strikes),
    .cell_valid     (cell_valid),
    .cell_ready     (cell_ready),
    .cell_index     (cell_index),
    .cell_digit     (cell_digit),
    .cell_highlight (cell_highlight),
    .busy           (busy),
    .frame_done     (frame_done),
    .hidden_count   (hidden_count),
    .won            (won),
    .lost           (lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    int   h;
    res_t r;
    h = 0;
    for (int n = 0; n < 81; n++) begin
      cell_t c;
      c.idx = n[6:0];
      c.dig = visibilities[n] ? board[4*n +: 4] : 4'd0;
      c.hl  = visibilities[n] &&
              (board[4*n +: 4] == selected_number);
      if (!visibilities[n]) h++;
      exp_q.push_back(c);
    end
    r.h = h[6:0];
    r.w = (h == 0);
    r.l = (strikes == 2'b11);
    res_q.push_back(r);
  endtask

  // Called at a falling edge with inputs for the next rising edge set.
  task automatic cyc();
    cell_t c;
    res_t  r;
    #1;
    cyc_n++;
    if (cell_valid && cell_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        chk("extra_xfer", 1, 0);
      end else begin
        c = exp_q.pop_front();
        chk("idx", 32'(cell_index), 32'(c.idx));
        chk("dig", 32'(cell_digit), 32'(c.dig));
        chk("hl", 32'(cell_highlight), 32'(c.hl));
      end
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc_n;
      if (res_q.size() == 0) begin
        chk("unexp_done", 1, 0);
      end else begin
        r = res_q.pop_front();
        chk("hidden", 32'(hidden_count), 32'(r.h));
        chk("won", 32'(won), 32'(r.w));
        chk("lost", 32'(lost), 32'(r.l));
        last_res = r;
      end
    end
    @(negedge clk);
  endtask

  task automatic start_frame();
    start = 1'b1;
    push_frame();
    t0 = cyc_n + 1;
    cyc();
    start = 1'b0;
    chk("lat_valid", 32'(cell_valid), 1);
    chk("lat_idx", 32'(cell_index), 0);
    chk("lat_busy", 32'(busy), 1);
  endtask

  task automatic run_to_done(input int bound);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < bound && done_cnt == d0; i++) cyc();
    chk("done_timeout", 32'(done_cnt != d0), 1);
  endtask

  task automatic run_to_idx(input int k, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (cell_valid && cell_index == 7'(k)) break;
      cyc();
    end
    chk("idx_timeout", 32'(i < bound), 1);
  endtask

  task automatic rand_board();
    for (int n = 0; n < 81; n++)
      board[4*n +: 4] = 4'($urandom_range(0, 15));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(cell_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_idx"}, 32'(cell_index), 0);
    chk({tag, "_dig"}, 32'(cell_digit), 0);
    chk({tag, "_hl"}, 32'(cell_highlight), 0);
    chk({tag, "_hid"}, 32'(hidden_count), 0);
    chk({tag, "_won"}, 32'(won), 0);
    chk({tag, "_lost"}, 32'(lost), 0);
  endtask

  initial begin
    int d0;
    int x0;
    int hold;
    bit mut;
    reset           = 1'b0;
    start           = 1'b0;
    cell_ready      = 1'b0;
    current_state   = 3'b100;
    board           = '0;
    visibilities    = '0;
    selected_number = 4'd1;
    strikes         = 2'b00;
    #1;
    chk_zero("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // All visible, full-speed frame.
    for (int n = 0; n < 81; n++)
      board[4*n +: 4] = 4'($urandom_range(1, 9));
    visibilities    = '1;
    selected_number = 4'd5;
    cell_ready      = 1'b1;
    x0 = xfer_cnt;
    start_frame();
    run_to_done(100);
    chk("A_done_cyc", 32'(done_cyc - t0), 82);
    chk("A_xfers", 32'(xfer_cnt - x0), 81);
    cyc();
    chk("A_won_hold", 32'(won), 1);
    chk("A_idle", 32'(busy), 0);

    // One hidden cell beside a highlighted one, out-of-range digit.
    rand_board();
    board[4*5 +: 4] = 4'd7;
    board[4*6 +: 4] = 4'd3;
    board[4*7 +: 4] = 4'hF;
    visibilities    = '1;
    visibilities[5] = 1'b0;
    selected_number = 4'd3;
    strikes         = 2'b01;
    start_frame();
    run_to_idx(5, 20);
    chk("B_c5_dig", 32'(cell_digit), 0);
    chk("B_c5_hl", 32'(cell_highlight), 0);
    cyc();
    chk("B_c6_dig", 32'(cell_digit), 3);
    chk("B_c6_hl", 32'(cell_highlight), 1);
    run_to_done(100);
    chk("B_hidden", 32'(hidden_count), 1);
    chk("B_won", 32'(won), 0);

    // Backpressure at index 10, inputs disturbed mid-frame.
    rand_board();
    visibilities    = 81'({$urandom(), $urandom(), $urandom()});
    selected_number = 4'($urandom_range(1, 9));
    strikes         = 2'b10;
    d0   = done_cnt;
    hold = 0;
    mut  = 1'b0;
    start_frame();
    for (int i = 0; i < 200 && done_cnt == d0; i++) begin
      if (cell_valid && cell_index == 7'd10 && hold < 4) begin
        cell_ready = 1'b0;
        hold++;
        chk("C_hold_idx", 32'(cell_index), 10);
        chk("C_hold_dig", 32'(cell_digit), 32'(exp_q[0].dig));
      end else begin
        cell_ready = 1'b1;
      end
      if (cell_valid && cell_index == 7'd30 && !mut) begin
        rand_board();
        visibilities    = ~visibilities;
        selected_number = selected_number ^ 4'd6;
        start = 1'b1;
        mut   = 1'b1;
      end else begin
        start = 1'b0;
      end
      cyc();
    end
    start      = 1'b0;
    cell_ready = 1'b1;
    chk("C_hold_cnt", 32'(hold), 4);
    repeat (5) cyc();
    chk("C_one_done", 32'(done_cnt - d0), 1);
    chk("C_busy", 32'(busy), 0);

    // Abort at index 40, ignored start outside the scan state.
    d0 = done_cnt;
    start_frame();
    run_to_idx(40, 60);
    current_state = 3'b010;
    cyc();
    chk("D_valid", 32'(cell_valid), 0);
    chk("D_busy", 32'(busy), 0);
    chk("D_hidden", 32'(hidden_count), 32'(last_res.h));
    chk("D_won", 32'(won), 32'(last_res.w));
    chk("D_lost", 32'(lost), 32'(last_res.l));
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("D_ign_busy", 32'(busy), 0);
    chk("D_ign_valid", 32'(cell_valid), 0);
    chk("D_no_done", 32'(done_cnt - d0), 0);
    exp_q.delete();
    res_q.delete();
    current_state = 3'b100;
    start_frame();
    run_to_done(100);

    // Abort coinciding with the last transfer still completes.
    d0 = done_cnt;
    start_frame();
    run_to_idx(80, 100);
    current_state = 3'b010;
    cyc();
    chk("F_done", 32'(frame_done), 1);
    chk("F_cnt", 32'(done_cnt - d0), 0);
    cyc();
    chk("F_cnt2", 32'(done_cnt - d0), 1);
    current_state = 3'b100;

    // Reset mid-frame, then a full frame with three strikes.
    strikes = 2'b11;
    d0 = done_cnt;
    start_frame();
    run_to_idx(20, 40);
    reset = 1'b0;
    #1;
    chk_zero("E_rst");
    @(negedge clk);
    reset = 1'b1;
    chk("E_no_done", 32'(done_cnt - d0), 0);
    exp_q.delete();
    res_q.delete();
    start_frame();
    run_to_done(100);
    chk("E_lost", 32'(lost), 1);
    chk("E_left", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
